// File: rtl/exec_unit.sv
// exec_unit -- execute/writeback stage between the regfile read ports and
// its write port.
//
// Build option: define EXEC_MUL_EN to include the iterative shift-add
// multiplier (op 10). Without it, op 10 is reported as illegal, busy is
// tied low and in_ready is tied high.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   issue handshake; accept = in_valid & in_ready
//   op                  0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA
//                       8 SLT 9 SLTU 10 MUL, 11-15 illegal
//   rd_in, a, b         destination address and operands (rv1/rv2)
//   we, rd, wb_data     regfile write-back triple (we is a 1-cycle pulse)
//   busy                multiply in progress
//   illegal             1-cycle pulse after an illegal op is accepted
module exec_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [AW-1:0]   rd_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            we,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_legal;
  logic            accept;
  logic            mul_op;
  logic            mul_start;

  assign shamt = b[SHW-1:0];

  // Single-cycle ALU; op 10 falls into the default arm and is handled by
  // the multiplier (or reported illegal when the multiplier is absent).
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: alu_legal = 1'b0;
    endcase
  end

  assign mul_start = accept && mul_op;

`ifdef EXEC_MUL_EN
  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] acc_q, ma_q, mb_q, acc_next;
  logic [AW-1:0]   mrd_q;
  logic            mul_last;

  assign mul_op   = (op == OP_MUL);
  assign accept   = in_valid && in_ready;
  assign mul_last = (state_q == S_MUL) && (cnt_q == SHW'(XLEN-1));

  // ma_q is shifted left and mb_q right once per step, so ma_q always
  // equals a << cnt and mb_q[0] is bit cnt of the original b.
  assign acc_next = acc_q + (mb_q[0] ? ma_q : '0);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_start) state_d = S_MUL;
      end
      S_MUL: begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (mul_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      mrd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        cnt_q <= '0;
        acc_q <= '0;
        ma_q  <= a;
        mb_q  <= b;
        mrd_q <= rd_in;
      end else if (state_q == S_MUL) begin
        cnt_q <= cnt_q + SHW'(1);
        acc_q <= acc_next;
        ma_q  <= ma_q << 1;
        mb_q  <= mb_q >> 1;
      end
    end
  end
`else
  assign mul_op   = 1'b0;
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
  assign accept   = in_valid;
`endif

  // Write-back registers; we and illegal default low so each is a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      rd      <= '0;
      wb_data <= '0;
      illegal <= 1'b0;
    end else begin
      we      <= 1'b0;
      illegal <= 1'b0;
      if (accept) begin
        if (alu_legal) begin
          we      <= (rd_in != '0);
          rd      <= rd_in;
          wb_data <= alu_res;
        end else if (!mul_start) begin
          illegal <= 1'b1;
        end
      end
`ifdef EXEC_MUL_EN
      if (mul_last) begin
        we      <= (mrd_q != '0);
        rd      <= mrd_q;
        wb_data <= acc_next;
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed steps followed by randomized
// issues checked against an arithmetic reference model.
module tb_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        illegal;

  int n_vec;
  int n_err;

  exec_unit #(.XLEN(32), .AW(5), .SHW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rd_in    (rd_in),
    .a        (a),
    .b        (b),
    .we       (we),
    .rd       (rd),
    .wb_data  (wb_data),
    .busy     (busy),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Reference model: results derived with plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] y, output logic legal,
                                 output logic [31:0] res);
    longint          sx, sy, d, q;
    longint unsigned p;
    int unsigned     sh;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sh  = y % 32;
    legal = 1'b1;
    res   = '0;
    case (o)
      4'd0: begin p = 64'(x) + 64'(y); res = p[31:0]; end
      4'd1: begin p = 64'(x) + (64'd4294967296 - 64'(y)); res = p[31:0]; end
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: res = x ^ y;
      4'd5: begin p = 64'(x) * (64'd1 << sh); res = p[31:0]; end
      4'd6: res = x / (32'd1 << sh);
      4'd7: begin
        d = longint'(64'd1 << sh);
        q = (sx < 0) ? (sx - d + 1) / d : sx / d;
        res = q[31:0];
      end
      4'd8: res = (sx < sy) ? 32'd1 : 32'd0;
      4'd9: res = (64'(x) < 64'(y)) ? 32'd1 : 32'd0;
`ifdef EXEC_MUL_EN
      4'd10: begin p = 64'(x) * 64'(y); res = p[31:0]; end
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (stage assumed idle), then check its write-back.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input string tag);
    logic        legal;
    logic [31:0] res;
    bit          is_mul;
    ref_op(o, x, y, legal, res);
    is_mul = legal && (o == 4'd10);
    op = o; a = x; b = y; rd_in = r; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // operands are only guaranteed during the accept cycle
    in_valid = 1'b0; a = $urandom; b = $urandom; rd_in = 5'($urandom);
    if (is_mul) begin
      for (int i = 0; i < 32; i++) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".we_run"}, 32'(we), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk({tag, ".we"}, 32'(we), 32'(legal && (r != 5'd0)));
    chk({tag, ".illegal"}, 32'(illegal), 32'(!legal));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    if (legal) chk({tag, ".wb_data"}, wb_data, res);
    if (legal && r != 5'd0) chk({tag, ".rd"}, 32'(rd), 32'(r));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; rd_in = '0; a = '0; b = '0;

    // reset state
    #1;
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.rd", 32'(rd), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // ADD wraps; we pulses for one cycle, rd/wb_data then hold
    do_op(4'd0, 32'hFFFF_FFFF, 32'd2, 5'd3, "add_wrap");
    chk("add_wrap.wb_exact", wb_data, 32'h0000_0001);
    @(posedge clk); #1;
    chk("idle.we", 32'(we), 32'd0);
    chk("idle.rd_hold", 32'(rd), 32'd3);
    chk("idle.wb_hold", wb_data, 32'h0000_0001);

    // back-to-back SUB then SRA
    op = 4'd1; a = 32'd5; b = 32'd7; rd_in = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd7; a = 32'h8000_0000; b = 32'h24; rd_in = 5'd2;
    chk("b2b.sub.we", 32'(we), 32'd1);
    chk("b2b.sub.rd", 32'(rd), 32'd1);
    chk("b2b.sub.wb", wb_data, 32'hFFFF_FFFE);
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.sra.we", 32'(we), 32'd1);
    chk("b2b.sra.rd", 32'(rd), 32'd2);
    chk("b2b.sra.wb", wb_data, 32'hF800_0000);

    do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd4, "slt");
    chk("slt.exact", wb_data, 32'd1);
    do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd5, "sltu");
    chk("sltu.exact", wb_data, 32'd0);
    do_op(4'd0, 32'd10, 32'd20, 5'd0, "add_rd0");
    chk("add_rd0.wb_exact", wb_data, 32'd30);

    do_op(4'd12, 32'd1, 32'd2, 5'd6, "op12");
    chk("op12.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("op12.illegal_pulse", 32'(illegal), 32'd0);

`ifdef EXEC_MUL_EN
    // MUL with an ADD held on in_valid while it runs
    op = 4'd10; a = 32'd123; b = 32'd456; rd_in = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd0; a = 32'd100; b = 32'd23; rd_in = 5'd9;
    for (int i = 0; i < 32; i++) begin
      chk("mulh.in_ready", 32'(in_ready), 32'd0);
      chk("mulh.we", 32'(we), 32'd0);
      @(posedge clk); #1;
    end
    chk("mulh.wb_we", 32'(we), 32'd1);
    chk("mulh.wb_rd", 32'(rd), 32'd7);
    chk("mulh.wb_data", wb_data, 32'd56088);
    chk("mulh.ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mulh.add.we", 32'(we), 32'd1);
    chk("mulh.add.rd", 32'(rd), 32'd9);
    chk("mulh.add.wb", wb_data, 32'd123);

    do_op(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd8, "mul_ovf");
    chk("mul_ovf.exact", wb_data, 32'd0);

    // reset during a multiply aborts it with no write
    op = 4'd10; a = 32'd77; b = 32'd99; rd_in = 5'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mulrst.busy", 32'(busy), 32'd0);
    chk("mulrst.we", 32'(we), 32'd0);
    chk("mulrst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("mulrst.no_write", 32'(we), 32'd0);
    end
    chk("mulrst.ready_after", 32'(in_ready), 32'd1);
`else
    do_op(4'd10, 32'd123, 32'd456, 5'd7, "op10_off");
    chk("op10_off.in_ready", 32'(in_ready), 32'd1);
`endif

    // randomized issues against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  ro;
      logic [4:0]  rr;
      ro = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(ro, pick(), pick(), rr, $sformatf("rnd%0d.op%0d", n, ro));
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
